ysyx_25020047_ifu: RTL and testbench

Instruction fetch unit directly upstream of the decode stage. Holds the architectural fetch PC and issues one word read per instruction to instruction memory over a valid/ready request channel and a valid-only response channel. Presents the fetched instruction, its PC and snpc to decode via a valid/ready handshake. Accepts PC redirects (dnpc) from execute/writeback.

---
 rtl/ysyx_25020047_ifu.sv | 146 ++++++++++++++
 tb/tb_ysyx_25020047_ifu.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: one outstanding imem read, REQ/WAIT/HOLD sequencing, redirect handling.
// Optional macro IFU_PERF_EN builds the fetch/stall performance counters; otherwise they read as zero.
`timescale 1ns/1ps
module ysyx_25020047_ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc,
  output logic            fetch_err,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] WORD = XLEN'(4);

  state_t          state, state_next;
  logic [XLEN-1:0] pc_q, pc_next;
  logic [XLEN-1:0] inst_q, inst_next;
  logic            err_q, err_next;
  logic            kill_q, kill_next;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_low;

  // Targets are forced to word alignment; the dropped low bits are intentionally ignored.
  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_low = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_REQ;
      pc_q   <= RESET_PC;
      inst_q <= '0;
      err_q  <= 1'b0;
      kill_q <= 1'b0;
    end else begin
      state  <= state_next;
      pc_q   <= pc_next;
      inst_q <= inst_next;
      err_q  <= err_next;
      kill_q <= kill_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    inst_next  = inst_q;
    err_next   = err_q;
    kill_next  = kill_q;
    case (state)
      S_REQ: begin
        // A redirect wins over a same-cycle request handshake; the request is re-issued.
        if (redirect_valid) begin
          pc_next = redirect_target;
        end else if (imem_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
          if (imem_resp_valid) begin
            kill_next  = 1'b0;
            state_next = S_REQ;
          end else begin
            kill_next = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (kill_q) begin
            kill_next  = 1'b0;
            state_next = S_REQ;
          end else begin
            inst_next  = imem_resp_data;
            err_next   = imem_resp_err;
            state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_next    = redirect_target;
          state_next = S_REQ;
        end else if (inst_ready) begin
          pc_next    = pc_q + WORD;
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  // Request valid is held low for the whole time reset is asserted.
  assign imem_req_valid = (state == S_REQ) && rst;
  assign imem_addr      = pc_q;
  assign inst_valid     = (state == S_HOLD);
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign snpc           = pc_q + WORD;
  assign fetch_err      = err_q;

`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if ((state == S_HOLD) && inst_ready && !redirect_valid) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (state != S_HOLD) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Bench for ysyx_25020047_ifu: directed corner sequences, a vector table, and a random run
// checked against a program-order fetch model with a simple one-outstanding memory responder.
`timescale 1ns/1ps
module tb_ysyx_25020047_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        imem_resp_err = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] snpc;
  logic        fetch_err;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  always #5 clk = ~clk;

  ysyx_25020047_ifu #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .snpc           (snpc),
    .fetch_err      (fetch_err),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Memory model state
  bit          pend = 0;
  int          mem_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  int          mem_delay = 1;
  bit          rand_delay = 0;
  bit          ovr_en = 0;
  logic [31:0] ovr_addr = 32'h0;
  logic [31:0] ovr_data = 32'h0;
  logic        ovr_err = 1'b0;

  // Program-order reference: address of the next instruction decode should receive
  logic [31:0] exp_pc = RESET_PC;
  int          fetch_model = 0;
  int          stall_model = 0;
  int          cycle = 0;
  int          fire_cnt = 0;
  int          hand_cnt = 0;
  logic [31:0] last_fire_addr = 32'h0;
  logic [31:0] last_pc = 32'h0, last_inst = 32'h0, last_snpc = 32'h0;
  logic        last_err = 1'b0;
  int          hand_cycle[$];
  logic [31:0] hand_pc[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (ovr_en && a == ovr_addr) return ovr_data;
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    if (ovr_en && a == ovr_addr) return ovr_err;
    return (a[4:2] == 3'd5);
  endfunction

  task automatic step();
    logic        fire, resp_seen, hand, redir;
    logic [31:0] fire_addr;
    @(negedge clk);
    redir     = redirect_valid;
    fire      = imem_req_valid && imem_req_ready && !redir;
    fire_addr = imem_addr;
    resp_seen = imem_resp_valid;
    hand      = inst_valid && inst_ready;
    if (rst) begin
      if (fire) begin
        check("one_outstanding", {31'b0, pend}, 32'h0);
        check("req_addr", fire_addr, exp_pc);
      end
      if (redir) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (hand) begin
        check("dec_pc", pc, exp_pc);
        check("dec_inst", inst, mem_data(exp_pc));
        check("dec_snpc", snpc, exp_pc + 32'd4);
        check("dec_err", {31'b0, fetch_err}, {31'b0, mem_err(exp_pc)});
        $display("[%0d] decode pc=%08h inst=%08h snpc=%08h err=%0d", cycle, pc, inst, snpc, fetch_err);
        last_pc = pc; last_inst = inst; last_snpc = snpc; last_err = fetch_err;
        hand_cycle.push_back(cycle);
        hand_pc.push_back(pc);
        hand_cnt++;
        fetch_model++;
        exp_pc = exp_pc + 32'd4;
      end
      if (!inst_valid) stall_model++;
    end
    @(posedge clk);
    #1;
    cycle++;
    if (resp_seen) pend = 0;
    if (fire) begin
      pend           = 1;
      pend_addr      = fire_addr;
      mem_cnt        = rand_delay ? int'($urandom_range(1, 4)) : mem_delay;
      fire_cnt++;
      last_fire_addr = fire_addr;
    end
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom();
    imem_resp_err   = 1'($urandom_range(0, 1));
    if (pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_data(pend_addr);
        imem_resp_err   = mem_err(pend_addr);
      end
    end
  endtask

  task automatic run_until_hand(input int n, input int budget);
    int target;
    int k;
    target = hand_cnt + n;
    k = 0;
    while (hand_cnt < target && k < budget) begin
      step();
      k++;
    end
    check("hand_timeout", hand_cnt, target);
  endtask

  task automatic run_until_fire(input int n, input int budget);
    int target;
    int k;
    target = fire_cnt + n;
    k = 0;
    while (fire_cnt < target && k < budget) begin
      step();
      k++;
    end
    check("fire_timeout", fire_cnt, target);
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    exp_pc         = RESET_PC;
    fetch_model    = 0;
    stall_model    = 0;
    repeat (2) step();
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_pc", pc, RESET_PC);
    check("rst_inst", inst, 32'h0);
    check("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
    check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    check("rst_perf_stall", perf_stall_cnt, 32'h0);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [31:0] target;
    logic [31:0] data;
    logic        err;
    logic [31:0] exp_pc;
    logic [31:0] exp_snpc;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] snap_pc, snap_inst;
    logic        snap_err;
    int          snap_fire, base_hand, k;

    vecs[0] = '{32'h8000_0103, 32'hDEAD_BEEF, 1'b1, 32'h8000_0100, 32'h8000_0104, 32'hDEAD_BEEF, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[2] = '{32'h0000_0002, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'hCAFE_F00D, 1'b1};
    vecs[3] = '{32'h7FFF_FFFD, 32'h0000_0013, 1'b0, 32'h7FFF_FFFC, 32'h8000_0000, 32'h0000_0013, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'h8000_0004, 32'hFFFF_FFFF, 1'b0};

    // Sequential fetch at minimum latency
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    mem_delay      = 1;
    hand_cycle.delete();
    hand_pc.delete();
    run_until_hand(3, 40);
    if (hand_pc.size() >= 3) begin
      check("seq_pc0", hand_pc[0], 32'h8000_0000);
      check("seq_pc1", hand_pc[1], 32'h8000_0004);
      check("seq_pc2", hand_pc[2], 32'h8000_0008);
      check("seq_gap01", hand_cycle[1] - hand_cycle[0], 32'd3);
      check("seq_gap12", hand_cycle[2] - hand_cycle[1], 32'd3);
    end

    // Decode back-pressure in HOLD
    inst_ready = 1'b0;
    k = 0;
    while (!inst_valid && k < 20) begin step(); k++; end
    check("hold_reached", {31'b0, inst_valid}, 32'h1);
    snap_pc   = pc;
    snap_inst = inst;
    snap_err  = fetch_err;
    snap_fire = fire_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_pc", pc, snap_pc);
      check("hold_inst", inst, snap_inst);
      check("hold_err", {31'b0, fetch_err}, {31'b0, snap_err});
      check("hold_valid", {31'b0, inst_valid}, 32'h1);
      check("hold_no_req", {31'b0, imem_req_valid}, 32'h0);
    end
    check("hold_no_fire", fire_cnt, snap_fire);
    inst_ready = 1'b1;
    run_until_hand(1, 5);
    run_until_fire(1, 10);
    check("hold_next_addr", last_fire_addr, snap_pc + 32'd4);

    // Redirect while waiting; the stale response arrives later
    mem_delay = 3;
    run_until_fire(1, 20);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    step();
    redirect_valid = 1'b0;
    run_until_hand(1, 30);
    check("wait_redir_pc", last_pc, 32'h8000_0100);
    check("wait_redir_fire", last_fire_addr, 32'h8000_0100);

    // Redirect coinciding with the response
    mem_delay = 2;
    run_until_fire(1, 20);
    k = 0;
    while (!imem_resp_valid && k < 10) begin step(); k++; end
    check("resp_seen", {31'b0, imem_resp_valid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    run_until_hand(1, 30);
    check("same_redir_pc", last_pc, 32'h8000_0200);
    check("same_redir_fire", last_fire_addr, 32'h8000_0200);

    // Redirect in REQ with ready high: that handshake is not taken
    mem_delay = 1;
    k = 0;
    while (!imem_req_valid && k < 10) begin step(); k++; end
    snap_fire      = fire_cnt;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    step();
    redirect_valid = 1'b0;
    check("req_redir_nofire", fire_cnt, snap_fire);
    run_until_fire(1, 10);
    check("req_redir_addr", last_fire_addr, 32'h8000_0300);

    // Vector table: alignment, wraparound, fault propagation
    for (int i = 0; i < 5; i++) begin
      ovr_en         = 1;
      ovr_addr       = vecs[i].exp_pc;
      ovr_data       = vecs[i].data;
      ovr_err        = vecs[i].err;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = vecs[i].target;
      step();
      redirect_valid = 1'b0;
      run_until_hand(1, 30);
      check("vec_pc", last_pc, vecs[i].exp_pc);
      check("vec_snpc", last_snpc, vecs[i].exp_snpc);
      check("vec_inst", last_inst, vecs[i].exp_inst);
      check("vec_err", {31'b0, last_err}, {31'b0, vecs[i].exp_err});
      run_until_fire(1, 10);
      check("vec_next_addr", last_fire_addr, vecs[i].exp_snpc);
      ovr_en = 0;
    end

    // Reset in the middle of WAIT; the late response must be ignored
    mem_delay = 6;
    run_until_fire(1, 20);
    step();
    imem_req_ready = 1'b0;
    do_reset();
    k = 0;
    while (pend && k < 20) begin step(); k++; end
    check("late_resp_done", {31'b0, pend}, 32'h0);
    check("late_pc", pc, RESET_PC);
    check("late_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("late_req_valid", {31'b0, imem_req_valid}, 32'h1);
    imem_req_ready = 1'b1;
    mem_delay      = 1;
    run_until_hand(1, 20);
    check("late_first_pc", last_pc, RESET_PC);
    check("late_first_inst", last_inst, mem_data(RESET_PC));

    // Random traffic against the program-order model
    rand_delay = 1;
    base_hand  = hand_cnt;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom();
      step();
    end
    redirect_valid = 1'b0;
    check("rand_progress", {31'b0, (hand_cnt - base_hand) >= 100}, 32'h1);
`ifdef IFU_PERF_EN
    check("perf_fetch", perf_fetch_cnt, fetch_model);
    check("perf_stall", perf_stall_cnt, stall_model);
`else
    check("perf_fetch_tied", perf_fetch_cnt, 32'h0);
    check("perf_stall_tied", perf_stall_cnt, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
